// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle around one pipeline stage (upstream side + downstream side).
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Environment side: drives the upstream beat and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side: accepts upstream beats and presents the head downstream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Registered pipeline stage with a 2-entry skid buffer and synchronous flush.
// Every output, including in_ready, comes straight from a flop.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 16,
  parameter logic [DATA_W-1:0] NOP_VALUE  = DATA_W'(0),
  parameter bit                FLUSH_KEEP = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_stage_skid_if.slave       bus,
  input  logic                   flush_in,
  output logic                   flush_out,
  output logic [1:0]             occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic              flush_out_q, flush_out_d;
  logic              in_fire, out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Next state, storage and registered output values.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    flush_out_d = flush_in;

    if (flush_in) begin
      // Flush wins over everything; optionally the beat offered now survives.
      if (FLUSH_KEEP && in_fire) begin
        head_d  = bus.in_data;
        state_d = ST_ONE;
      end else begin
        state_d = ST_EMPTY;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_d  = bus.in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_d  = bus.in_data;
          end else if (in_fire) begin
            skid_d  = bus.in_data;
            state_d = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_q is low here, so only the drain path exists.
          if (out_fire) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    out_data_d  = out_valid_d ? head_d : NOP_VALUE;
    in_ready_d  = (state_d != ST_TWO);

    case (state_d)
      ST_ONE:  occupancy_d = 2'd1;
      ST_TWO:  occupancy_d = 2'd2;
      default: occupancy_d = 2'd0;
    endcase
  end

  // State and output registers; reset leaves the stage empty and showing a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= NOP_VALUE;
      occupancy_q <= 2'd0;
      flush_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      occupancy_q <= occupancy_d;
      flush_out_q <= flush_out_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign occupancy     = occupancy_q;
  assign flush_out     = flush_out_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed checks on two 16-bit stages (FLUSH_KEEP 0 and 1) driven identically,
// plus a random valid/ready run on a 32-bit stage against a reference queue.
module tb_pipe_stage_skid;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush2;
  logic fo0, fo1, fo2;
  logic [1:0] occ0, occ1, occ2;

  int n_checks;
  int n_fail;

  pipe_stage_skid_if #(.DATA_W(16)) if0 ();
  pipe_stage_skid_if #(.DATA_W(16)) if1 ();
  pipe_stage_skid_if #(.DATA_W(32)) if2 ();

  pipe_stage_skid #(.DATA_W(16), .NOP_VALUE(16'h0000), .FLUSH_KEEP(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .flush_in(flush), .flush_out(fo0), .occupancy(occ0)
  );
  pipe_stage_skid #(.DATA_W(16), .NOP_VALUE(16'h0000), .FLUSH_KEEP(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .flush_in(flush), .flush_out(fo1), .occupancy(occ1)
  );
  pipe_stage_skid #(.DATA_W(32), .NOP_VALUE(32'hDEADBEEF), .FLUSH_KEEP(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .flush_in(flush2), .flush_out(fo2), .occupancy(occ2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Same expected handshake/output state on both 16-bit stages.
  task automatic chk_both(input string tag, input logic v, input logic [15:0] d,
                          input logic [1:0] occ, input logic rdy);
    check_eq({tag, "_v0"},   32'(if0.out_valid), 32'(v));
    check_eq({tag, "_d0"},   32'(if0.out_data),  32'(d));
    check_eq({tag, "_occ0"}, 32'(occ0),          32'(occ));
    check_eq({tag, "_rdy0"}, 32'(if0.in_ready),  32'(rdy));
    check_eq({tag, "_v1"},   32'(if1.out_valid), 32'(v));
    check_eq({tag, "_d1"},   32'(if1.out_data),  32'(d));
    check_eq({tag, "_occ1"}, 32'(occ1),          32'(occ));
    check_eq({tag, "_rdy1"}, 32'(if1.in_ready),  32'(rdy));
  endtask

  task automatic drv(input logic v, input logic [15:0] d, input logic r, input logic f);
    if0.in_valid = v; if0.in_data = d; if0.out_ready = r;
    if1.in_valid = v; if1.in_data = d; if1.out_ready = r;
    flush = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic        hold;
  logic        in_fire, out_fire;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    flush2   = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;
    drv(1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk_both("rst", 1'b0, 16'h0000, 2'd0, 1'b1);
    check_eq("rst_fo0", 32'(fo0), 32'd0);
    check_eq("rst_d2",  if2.out_data, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Streaming with out_ready=1: one-cycle latency, never more than one entry.
    drv(1'b1, 16'h1111, 1'b1, 1'b0); step(); chk_both("s1", 1'b1, 16'h1111, 2'd1, 1'b1);
    drv(1'b1, 16'h2222, 1'b1, 1'b0); step(); chk_both("s2", 1'b1, 16'h2222, 2'd1, 1'b1);
    drv(1'b1, 16'h3333, 1'b1, 1'b0); step(); chk_both("s3", 1'b1, 16'h3333, 2'd1, 1'b1);
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(); chk_both("s4", 1'b0, 16'h0000, 2'd0, 1'b1);

    // Backpressure: fill both entries, hold off a third beat, then drain in order.
    drv(1'b1, 16'hAAAA, 1'b0, 1'b0); step(); chk_both("b1", 1'b1, 16'hAAAA, 2'd1, 1'b1);
    drv(1'b1, 16'hBBBB, 1'b0, 1'b0); step(); chk_both("b2", 1'b1, 16'hAAAA, 2'd2, 1'b0);
    drv(1'b1, 16'hCCCC, 1'b0, 1'b0); step(); chk_both("b3", 1'b1, 16'hAAAA, 2'd2, 1'b0);
    drv(1'b1, 16'hCCCC, 1'b1, 1'b0); step(); chk_both("b4", 1'b1, 16'hBBBB, 2'd1, 1'b1);
    drv(1'b1, 16'hCCCC, 1'b1, 1'b0); step(); chk_both("b5", 1'b1, 16'hCCCC, 2'd1, 1'b1);
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(); chk_both("b6", 1'b0, 16'h0000, 2'd0, 1'b1);

    // Flush a full stage while 0xDDDD is offered (in_ready=0, so nothing fires).
    drv(1'b1, 16'h1234, 1'b0, 1'b0); step();
    drv(1'b1, 16'h5678, 1'b0, 1'b0); step(); chk_both("f_full", 1'b1, 16'h1234, 2'd2, 1'b0);
    drv(1'b1, 16'hDDDD, 1'b0, 1'b1); step(); chk_both("f_a", 1'b0, 16'h0000, 2'd0, 1'b1);
    check_eq("f_a_fo0", 32'(fo0), 32'd1);
    check_eq("f_a_fo1", 32'(fo1), 32'd1);
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(); chk_both("f_a2", 1'b0, 16'h0000, 2'd0, 1'b1);
    check_eq("f_a2_fo0", 32'(fo0), 32'd0);

    // Flush with one entry held and 0xDDDD firing: only FLUSH_KEEP=1 keeps it.
    drv(1'b1, 16'h1234, 1'b0, 1'b0); step(); chk_both("f_one", 1'b1, 16'h1234, 2'd1, 1'b1);
    drv(1'b1, 16'hDDDD, 1'b0, 1'b1); step();
    check_eq("f_b_v0",   32'(if0.out_valid), 32'd0);
    check_eq("f_b_d0",   32'(if0.out_data),  32'h0000);
    check_eq("f_b_occ0", 32'(occ0),          32'd0);
    check_eq("f_b_fo0",  32'(fo0),           32'd1);
    check_eq("f_b_v1",   32'(if1.out_valid), 32'd1);
    check_eq("f_b_d1",   32'(if1.out_data),  32'hDDDD);
    check_eq("f_b_occ1", 32'(occ1),          32'd1);
    check_eq("f_b_fo1",  32'(fo1),           32'd1);
    drv(1'b0, 16'h0000, 1'b1, 1'b0); step(); chk_both("f_b2", 1'b0, 16'h0000, 2'd0, 1'b1);

    // Asynchronous reset mid-transfer with both entries full.
    drv(1'b1, 16'h4444, 1'b0, 1'b0); step();
    drv(1'b1, 16'h5555, 1'b0, 1'b0); step(); chk_both("r_full", 1'b1, 16'h4444, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_both("r_async", 1'b0, 16'h0000, 2'd0, 1'b1);
    drv(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_both("r_after", 1'b0, 16'h0000, 2'd0, 1'b1);

    // Random valid/ready on the 32-bit stage, compared against a reference FIFO.
    hold = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      check_eq("rnd_occ", 32'(occ2), 32'(q.size()));
      check_eq("rnd_vld", 32'(if2.out_valid), 32'(q.size() != 0));
      check_eq("rnd_rdy", 32'(if2.in_ready), 32'(q.size() < 2));
      if (q.size() != 0) check_eq("rnd_head", if2.out_data, q[0]);
      else               check_eq("rnd_nop",  if2.out_data, 32'hDEADBEEF);
      if (!hold) begin
        if2.in_valid = ($urandom_range(0, 99) < 60);
        if2.in_data  = $urandom;
      end
      if2.out_ready = ($urandom_range(0, 99) < 50);
      in_fire  = if2.in_valid & if2.in_ready;
      out_fire = if2.out_valid & if2.out_ready;
      if (out_fire && q.size() != 0) void'(q.pop_front());
      if (in_fire) q.push_back(if2.in_data);
      hold = if2.in_valid & ~in_fire;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
